// File: rtl/bt_result_display.sv
// bt_result_display
//   Final stage of the balanced-ternary calculator. It accepts a 4-trit result
//   word over a valid/ready handshake and checks the trit encoding. It converts
//   the word to a signed integer with four Horner steps, most significant trit
//   first. It then drives a 3-digit multiplexed 7-segment display showing the
//   sign, tens and ones of the result.
//
//   Optional feature macro: BTDISP_LZB_EN (leading-zero blanking of the tens
//   digit on legal results).
//
// Parameters
//   SCAN_DIV     clock cycles each display digit stays enabled (>= 1)
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   res_word     result word; trit k at bits [7-2k:6-2k], t0 at bits 7:6
//                encoding 01=-1, 11=0, 10=+1, 00=illegal
//   res_valid    res_word valid
//   res_ready    block can accept (IDLE only), decoded from state
//   value        signed result, -40..+40, two's complement
//   value_valid  one-cycle pulse when value/err update
//   err          last accepted word held an illegal trit
//   seg          {g,f,e,d,c,b,a}, active-high
//   dig_an       active-low digit enables: bit0 ones, bit1 tens, bit2 sign
module bt_result_display #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] res_word,
  input  logic       res_valid,
  output logic       res_ready,
  output logic [6:0] value,
  output logic       value_valid,
  output logic       err,
  output logic [6:0] seg,
  output logic [2:0] dig_an
);

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned VAL_W   = 7;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned MAG_W   = 6;
  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h40;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h3F;
`ifdef BTDISP_LZB_EN
  localparam logic [SEG_W-1:0] TENS_RST  = SEG_BLANK;
`else
  localparam logic [SEG_W-1:0] TENS_RST  = SEG_ZERO;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] word_q, word_d;
  logic [VAL_W-1:0]  acc_q, acc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              load_c;

  logic [VAL_W-1:0]  value_q;
  logic              err_q;
  logic              vv_q;
  logic [SEG_W-1:0]  sign_q, tens_q, ones_q;

  logic [PRESC_W-1:0] presc_q;
  logic [1:0]         idx_q;

  // Trit value as a 7-bit two's-complement addend; illegal 00 adds nothing.
  function automatic logic [VAL_W-1:0] trit_val(input logic [1:0] t);
    case (t)
      2'b01:   trit_val = 7'h7F;
      2'b10:   trit_val = 7'h01;
      default: trit_val = 7'h00;
    endcase
  endfunction

  // 7-segment font for decimal digits.
  function automatic logic [SEG_W-1:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'h3F;
      4'd1:    font = 7'h06;
      4'd2:    font = 7'h5B;
      4'd3:    font = 7'h4F;
      4'd4:    font = 7'h66;
      4'd5:    font = 7'h6D;
      4'd6:    font = 7'h7D;
      4'd7:    font = 7'h07;
      4'd8:    font = 7'h7F;
      4'd9:    font = 7'h6F;
      default: font = SEG_BLANK;
    endcase
  endfunction

  // Trit selected for the current Horner step: cnt 0 picks t3 (bits 1:0).
  logic [1:0] cur_trit;
  always_comb begin
    cur_trit = word_q[1:0];
    case (cnt_q)
      2'd0: cur_trit = word_q[1:0];
      2'd1: cur_trit = word_q[3:2];
      2'd2: cur_trit = word_q[5:4];
      2'd3: cur_trit = word_q[7:6];
      default: cur_trit = word_q[1:0];
    endcase
  end

  // Any 00 pair in the captured word marks it illegal.
  logic illegal;
  assign illegal = (word_q[1:0] == 2'b00) || (word_q[3:2] == 2'b00) ||
                   (word_q[5:4] == 2'b00) || (word_q[7:6] == 2'b00);

  // Magnitude split into tens/ones by a comparison chain (|acc| <= 40).
  logic [MAG_W-1:0] mag, rem;
  logic [3:0]       tens_dig, ones_dig;
  always_comb begin
    mag      = acc_q[VAL_W-1] ? MAG_W'(-acc_q) : MAG_W'(acc_q);
    tens_dig = 4'd0;
    rem      = mag;
    if (mag >= 6'd40) begin
      tens_dig = 4'd4;
      rem      = mag - 6'd40;
    end else if (mag >= 6'd30) begin
      tens_dig = 4'd3;
      rem      = mag - 6'd30;
    end else if (mag >= 6'd20) begin
      tens_dig = 4'd2;
      rem      = mag - 6'd20;
    end else if (mag >= 6'd10) begin
      tens_dig = 4'd1;
      rem      = mag - 6'd10;
    end
    ones_dig = 4'(rem);
  end

  // Digit patterns to be loaded for the finished conversion.
  logic [SEG_W-1:0] sign_nx, tens_nx, ones_nx;
  logic [VAL_W-1:0] value_nx;
  always_comb begin
    value_nx = acc_q;
    sign_nx  = acc_q[VAL_W-1] ? SEG_MINUS : SEG_BLANK;
    tens_nx  = font(tens_dig);
    ones_nx  = font(ones_dig);
`ifdef BTDISP_LZB_EN
    if (tens_dig == 4'd0) tens_nx = SEG_BLANK;
`endif
    if (illegal) begin
      value_nx = '0;
      sign_nx  = SEG_E;
      tens_nx  = SEG_MINUS;
      ones_nx  = SEG_MINUS;
    end
  end

  // FSM next state and conversion datapath.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (res_valid) begin
          word_d  = res_word;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        acc_d = VAL_W'(acc_q + acc_q + acc_q + trit_val(cur_trit));
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_ready = (state_q == S_IDLE);

  // FSM state and conversion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result and display registers; only LOAD changes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      err_q   <= 1'b0;
      vv_q    <= 1'b0;
      sign_q  <= SEG_BLANK;
      tens_q  <= TENS_RST;
      ones_q  <= SEG_ZERO;
    end else begin
      vv_q <= load_c;
      if (load_c) begin
        value_q <= value_nx;
        err_q   <= illegal;
        sign_q  <= sign_nx;
        tens_q  <= tens_nx;
        ones_q  <= ones_nx;
      end
    end
  end

  // Free-running scan prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // Digit enable and segment mux, decoded from registered index/patterns.
  always_comb begin
    seg    = SEG_BLANK;
    dig_an = 3'b111;
    case (idx_q)
      2'd0: begin seg = ones_q; dig_an = 3'b110; end
      2'd1: begin seg = tens_q; dig_an = 3'b101; end
      2'd2: begin seg = sign_q; dig_an = 3'b011; end
      default: begin seg = SEG_BLANK; dig_an = 3'b111; end
    endcase
  end

  assign value       = value_q;
  assign err         = err_q;
  assign value_valid = vv_q;

endmodule
